// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative 32-bit multiply/divide unit feeding the register file's HI/LO
// write port. One operation runs for 32 CALC iterations and then a single
// DONE cycle in which hi_write/lo_write pulse with the registered result.
//
// Ports:
//   clk        in   clock, rising-edge
//   rst        in   asynchronous active-high reset
//   start      in   operation request, sampled only while idle
//   op[1:0]    in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data    in   operand A (multiplicand / dividend)
//   rt_data    in   operand B (multiplier / divisor)
//   busy       out  high while an operation is in flight (CALC or DONE)
//   hi_write   out  one-cycle strobe, result valid
//   lo_write   out  identical to hi_write
//   hi_result  out  product[63:32] or remainder
//   lo_result  out  product[31:0] or quotient
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        hi_write,
  output logic        lo_write,
  output logic [31:0] hi_result,
  output logic [31:0] lo_result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        div_q, div_d;      // operation class: 1 = divide
  logic [31:0] a_q, a_d;          // |operand A|
  logic [31:0] b_q, b_d;          // |operand B|
  logic        neg_q, neg_d;      // product / quotient sign
  logic        rneg_q, rneg_d;    // remainder sign (dividend sign)
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;      // product, or quotient in [31:0]
  logic [31:0] rem_q, rem_d;      // partial remainder
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Operand conditioning at start: unsigned ops never see a sign bit.
  logic        sgn_op, sa, sb;
  logic [31:0] rs_mag, rt_mag;

  assign sgn_op = ~op[0];
  assign sa     = sgn_op & rs_data[31];
  assign sb     = sgn_op & rt_data[31];
  assign rs_mag = sa ? (~rs_data + 32'd1) : rs_data;
  assign rt_mag = sb ? (~rt_data + 32'd1) : rt_data;

  // Restoring divide step: shift in the next dividend bit (MSB first) and
  // try to subtract the divisor. The shifted value needs 33 bits because
  // the running remainder can be up to divisor-1 before the shift.
  logic [32:0] shifted, diff;
  logic        q_bit;

  assign shifted = {1'b0, rem_q} << 1 | {32'd0, a_q[cnt_q]};
  assign diff    = shifted - {1'b0, b_q};
  assign q_bit   = ~diff[32];

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          div_d   = op[1];
          a_d     = rs_mag;
          b_d     = rt_mag;
          neg_d   = sa ^ sb;
          rneg_d  = sa;
          cnt_d   = 5'd31;
          acc_d   = 64'd0;
          rem_d   = 32'd0;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        if (div_q) begin
          rem_d = q_bit ? diff[31:0] : shifted[31:0];
          acc_d = {acc_q[62:0], q_bit};
        end else begin
          // MSB-first shift-add over the multiplier bits.
          acc_d = (acc_q << 1) + (b_q[cnt_q] ? {32'd0, a_q} : 64'd0);
        end

        if (cnt_q == 5'd0) begin
          state_d = S_DONE;
          if (!div_q) begin
            {hi_d, lo_d} = neg_q ? (~acc_d + 64'd1) : acc_d;
          end else if (b_q == 32'd0) begin
            // Divide by zero: hand back the original dividend, all-ones
            // quotient. Re-applying the dividend sign restores rs_data.
            hi_d = rneg_q ? (~a_q + 32'd1) : a_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            lo_d = neg_q  ? (~acc_d[31:0] + 32'd1) : acc_d[31:0];
            hi_d = rneg_q ? (~rem_d + 32'd1) : rem_d;
          end
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= 5'd0;
      acc_q   <= 64'd0;
      rem_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Strobes decode straight from the state register so an asynchronous
  // reset during DONE removes them immediately.
  assign busy      = (state_q != S_IDLE);
  assign hi_write  = (state_q == S_DONE);
  assign lo_write  = hi_write;
  assign hi_result = hi_q;
  assign lo_result = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] hi_result;
  logic [31:0] lo_result;

  int tests = 0;
  int fails = 0;

  muldiv_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .busy     (busy),
    .hi_write (hi_write),
    .lo_write (lo_write),
    .hi_result(hi_result),
    .lo_result(lo_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    bit          pulse;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: p = 64'(sa * sb);
      2'd1: p = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    hi = p[63:32];
    lo = p[31:0];
  endfunction

  // Called #1 after a rising edge. Issues one operation, then scrambles the
  // operand inputs and watches up to 40 edges for the write strobe.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit pulse,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output int lat, output int strobes, output int timeout,
                        output int wr_mis);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rs_data = $urandom; rt_data = $urandom; op = 2'($urandom);
    lat = 0; strobes = 0; timeout = 1; wr_mis = 0; hi = '0; lo = '0;
    for (int n = 1; n <= 40; n++) begin
      if (pulse && (n == 5 || n == 20)) begin
        start = 1'b1; rs_data = $urandom; rt_data = $urandom; op = 2'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (hi_write !== lo_write) wr_mis++;
      if (hi_write === 1'b1) begin
        strobes++;
        if (lat == 0) begin
          lat = n; hi = hi_result; lo = lo_result;
        end
      end
      if (busy === 1'b0) begin
        timeout = 0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic do_vec(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit pulse);
    logic [31:0] hi, lo;
    int lat, strobes, timeout, wr_mis;
    run_op(o, a, b, pulse, hi, lo, lat, strobes, timeout, wr_mis);
    $display("[TB] %s op=%0d a=%08h b=%08h -> hi=%08h lo=%08h lat=%0d strobes=%0d",
             name, o, a, b, hi, lo, lat, strobes);
    check({name, " hi"}, hi, exp_hi);
    check({name, " lo"}, lo, exp_lo);
    // Strobe sits between the 32nd and 33rd edge after the start edge.
    check({name, " latency"}, 32'(lat), 32'd32);
    check({name, " strobes"}, 32'(strobes), 32'd1);
    check({name, " timeout"}, 32'(timeout), 32'd0);
    check({name, " lo_write==hi_write"}, 32'(wr_mis), 32'd0);
  endtask

  logic [31:0] specials [5];

  initial begin
    logic [31:0] eh, el, ra, rb;
    logic [1:0]  ro;
    int          strobes;

    specials[0] = 32'h0000_0000; specials[1] = 32'h0000_0001;
    specials[2] = 32'hFFFF_FFFF; specials[3] = 32'h8000_0000;
    specials[4] = 32'h7FFF_FFFF;

    vecs[0]  = '{"multu_max",   2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{"mult_neg3x5", 2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2]  = '{"mult_minsq",  2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[3]  = '{"divu_100_7",  2'd3, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[4]  = '{"div_m7_2",    2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{"divu_by0",    2'd3, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{"div_ovf",     2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[7]  = '{"div_7_m2",    2'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[8]  = '{"div_neg_by0", 2'd2, 32'h8000_0005, 32'd0,         32'h8000_0005, 32'hFFFF_FFFF, 1'b0};
    vecs[9]  = '{"start_busy",  2'd1, 32'h0001_0003, 32'h0000_0010, 32'h0000_0000, 32'h0010_0030, 1'b1};
    vecs[10] = '{"multu_3x4",   2'd1, 32'd3,         32'd4,         32'h0000_0000, 32'h0000_000C, 1'b0};

    rst = 1'b1; start = 1'b0; op = 2'd0; rs_data = '0; rt_data = '0;
    @(posedge clk); #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset hi_write", 32'(hi_write), 32'd0);
    check("reset hi_result", hi_result, 32'd0);
    check("reset lo_result", lo_result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      do_vec(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].pulse);
    end

    // Results hold after the strobe.
    repeat (5) @(posedge clk);
    #1;
    check("hold lo", lo_result, 32'h0000_000C);

    // Reset in mid-CALC: abort, clear, no strobe afterwards.
    op = 2'd1; rs_data = 32'h0001_0000; rt_data = 32'h0001_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("calc rst busy", 32'(busy), 32'd0);
    check("calc rst hi_write", 32'(hi_write), 32'd0);
    check("calc rst hi_result", hi_result, 32'd0);
    check("calc rst lo_result", lo_result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    strobes = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (hi_write === 1'b1) strobes++;
    end
    check("calc rst no strobe", 32'(strobes), 32'd0);
    $display("[TB] reset mid-CALC: strobes after abort=%0d", strobes);
    do_vec("post_rst_multu_3x4", 2'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

    // Reset during the DONE cycle drops the strobe and clears the result.
    op = 2'd1; rs_data = 32'd6; rt_data = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    check("done strobe", 32'(hi_write), 32'd1);
    check("done lo", lo_result, 32'd42);
    rst = 1'b1;
    #1;
    check("done rst hi_write", 32'(hi_write), 32'd0);
    check("done rst lo_write", 32'(lo_write), 32'd0);
    check("done rst lo_result", lo_result, 32'd0);
    $display("[TB] reset in DONE: hi_write=%0b lo_result=%08h", hi_write, lo_result);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 32'($urandom);
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
      ref_model(ro, ra, rb, eh, el);
      do_vec("random", ro, ra, rb, eh, el, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
